// File: rtl/btn_debounce_pkg.sv
// Shared types and sizing helpers for the push-button debouncer array.
package btn_debounce_pkg;

    typedef enum logic [2:0] {IDLE, ARM, HELD, REPEAT, REL_ARM} dbn_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounced button channel: two-flop synchroniser, shared down-the-path counter
// and a press/release/auto-repeat state machine with registered pulse outputs.
//
// state   | meaning
// IDLE    | released and stable, waiting for a 1
// ARM     | qualifying a press, level still 0
// HELD    | accepted press, timing the first repeat
// REPEAT  | held past the repeat delay, emitting periodic repeats
// REL_ARM | qualifying a release, level still 1
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1048576,
    parameter int REPEAT_EN    = 0,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic pressed,
    output logic released,
    output logic repeat_p
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_RATE) + 1);
    localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_TC  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] RATE_TC = CNT_W'(REPEAT_RATE - 1);

    logic ff1, ff2;
    dbn_state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic level_nx, pressed_nx, released_nx, repeat_nx;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        level_nx    = level;
        pressed_nx  = 1'b0;
        released_nx = 1'b0;
        repeat_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ff2) begin
                    state_nx = ARM;
                    cnt_nx   = '0;
                end
            end
            ARM: begin
                if (!ff2) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DEB_TC) begin
                    state_nx   = HELD;
                    level_nx   = 1'b1;
                    pressed_nx = 1'b1;
                    cnt_nx     = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!ff2) begin
                    state_nx = REL_ARM;
                    cnt_nx   = '0;
                end else if (REPEAT_EN != 0) begin
                    if (cnt == DLY_TC) begin
                        state_nx  = REPEAT;
                        repeat_nx = 1'b1;
                        cnt_nx    = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            REPEAT: begin
                if (!ff2) begin
                    state_nx = REL_ARM;
                    cnt_nx   = '0;
                end else if (cnt == RATE_TC) begin
                    repeat_nx = 1'b1;
                    cnt_nx    = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            REL_ARM: begin
                // A bounce back to 1 returns to HELD, which also restarts the repeat delay.
                if (ff2) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else if (cnt == DEB_TC) begin
                    state_nx    = IDLE;
                    level_nx    = 1'b0;
                    released_nx = 1'b1;
                    cnt_nx      = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                level_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1      <= 1'b0;
            ff2      <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            level    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
            repeat_p <= 1'b0;
        end else begin
            ff1      <= btn;
            ff2      <= ff1;
            state    <= state_nx;
            cnt      <= cnt_nx;
            level    <= level_nx;
            pressed  <= pressed_nx;
            released <= released_nx;
            repeat_p <= repeat_nx;
        end
    end

endmodule

// File: rtl/btn_debounce_array.sv
// Array of independent debounced button channels feeding the game-control FSM.
module btn_debounce_array
    import btn_debounce_pkg::*;
#(
    parameter int NUM_CH       = 5,
    parameter int DEBOUNCE_CYC = 1048576,
    parameter int REPEAT_EN    = 0,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] btn,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] pressed,
    output logic [NUM_CH-1:0] released,
    output logic [NUM_CH-1:0] repeat_p
);

    if (DEBOUNCE_CYC < 1) begin : g_bad_deb
        $error("btn_debounce_array: DEBOUNCE_CYC must be >= 1");
    end
    if (REPEAT_DLY < 1) begin : g_bad_dly
        $error("btn_debounce_array: REPEAT_DLY must be >= 1");
    end
    if (REPEAT_RATE < 1) begin : g_bad_rate
        $error("btn_debounce_array: REPEAT_RATE must be >= 1");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .REPEAT_EN   (REPEAT_EN),
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn     (btn[i]),
            .level   (level[i]),
            .pressed (pressed[i]),
            .released(released[i]),
            .repeat_p(repeat_p[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Bench for btn_debounce_array: directed timing scenarios plus random bouncing,
// compared every cycle against a run-length reference model.
module tb_btn_debounce_array;

    localparam int NUM_CH = 5;
    localparam int DEB    = 4;
    localparam int DLY    = 8;
    localparam int RATE   = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [NUM_CH-1:0] btn;
    logic [NUM_CH-1:0] level0, pressed0, released0, rep0;
    logic [NUM_CH-1:0] level1, pressed1, released1, rep1;

    always #5 clk = ~clk;

    btn_debounce_array #(
        .NUM_CH(NUM_CH), .DEBOUNCE_CYC(DEB), .REPEAT_EN(0),
        .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)
    ) dut_norep (
        .clk(clk), .rst_n(rst_n), .btn(btn),
        .level(level0), .pressed(pressed0), .released(released0), .repeat_p(rep0)
    );

    btn_debounce_array #(
        .NUM_CH(NUM_CH), .DEBOUNCE_CYC(DEB), .REPEAT_EN(1),
        .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)
    ) dut_rep (
        .clk(clk), .rst_n(rst_n), .btn(btn),
        .level(level1), .pressed(pressed1), .released(released1), .repeat_p(rep1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: press needs DEB+1 consecutive 1 samples while released,
    // release needs DEB+1 consecutive 0 samples while held; repeats are counted
    // from the last press or from the last return to 1 during a held period.
    logic [NUM_CH-1:0] m_f1, m_f2, m_lvl, m_p, m_r, m_rep;
    int run1[NUM_CH];
    int run0[NUM_CH];
    int hold[NUM_CH];

    always @(posedge clk or negedge rst_n) begin
        logic [NUM_CH-1:0] s;
        if (!rst_n) begin
            m_f1 = '0; m_f2 = '0; m_lvl = '0; m_p = '0; m_r = '0; m_rep = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                run1[i] = 0; run0[i] = 0; hold[i] = 0;
            end
        end else begin
            s = m_f2; m_f2 = m_f1; m_f1 = btn;
            m_p = '0; m_r = '0; m_rep = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!m_lvl[i]) begin
                    if (s[i]) run1[i]++; else run1[i] = 0;
                    if (run1[i] == DEB + 1) begin
                        m_lvl[i] = 1'b1; m_p[i] = 1'b1;
                        run1[i] = 0; run0[i] = 0; hold[i] = 0;
                    end
                end else if (s[i]) begin
                    if (run0[i] > 0) hold[i] = 0;
                    else begin
                        hold[i]++;
                        if (hold[i] >= DLY && ((hold[i] - DLY) % RATE) == 0) m_rep[i] = 1'b1;
                    end
                    run0[i] = 0;
                end else begin
                    run0[i]++;
                    if (run0[i] == DEB + 1) begin
                        m_lvl[i] = 1'b0; m_r[i] = 1'b1; run0[i] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("norep_level",    32'(level0),    32'(m_lvl));
        check("norep_pressed",  32'(pressed0),  32'(m_p));
        check("norep_released", 32'(released0), 32'(m_r));
        check("norep_repeat",   32'(rep0),      32'd0);
        check("rep_level",      32'(level1),    32'(m_lvl));
        check("rep_pressed",    32'(pressed1),  32'(m_p));
        check("rep_released",   32'(released1), 32'(m_r));
        check("rep_repeat",     32'(rep1),      32'(m_rep));
    end

    initial begin
        rst_n = 1'b0;
        btn   = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({level0, pressed0, released0, rep0}), 32'd0);
        rst_n = 1'b1;

        // clean press on channel 0
        @(negedge clk); btn[0] = 1'b1;
        repeat (6) @(negedge clk);
        check("press_before_edge7", 32'(pressed0[0]), 32'd0);
        @(negedge clk);
        check("press_at_edge7", 32'(pressed0[0]), 32'd1);
        check("press_level", 32'(level0[0]), 32'd1);
        @(negedge clk);
        check("press_one_cycle", 32'(pressed0[0]), 32'd0);

        // bounce rejection on channel 1
        for (int c = 0; c < 20; c++) begin
            btn[1] = ((c % 4) != 3);
            @(negedge clk);
        end
        check("bounce_level", 32'(level0[1]), 32'd0);
        btn[1] = 1'b1;
        repeat (6) @(negedge clk);
        check("bounce_then_steady_early", 32'(pressed0[1]), 32'd0);
        @(negedge clk);
        check("bounce_then_steady_press", 32'(pressed0[1]), 32'd1);

        // release with a 2-cycle glitch on channel 0
        btn[0] = 1'b0; repeat (2) @(negedge clk);
        btn[0] = 1'b1; repeat (2) @(negedge clk);
        btn[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("release_early", 32'(released0[0]), 32'd0);
        check("release_level_held", 32'(level0[0]), 32'd1);
        @(negedge clk);
        check("release_at_edge7", 32'(released0[0]), 32'd1);
        check("release_level_low", 32'(level0[0]), 32'd0);

        // auto-repeat on channel 2
        btn[2] = 1'b1;
        repeat (7) @(negedge clk);
        check("rpt_pressed", 32'(pressed1[2]), 32'd1);
        repeat (7) @(negedge clk);
        check("rpt_before_first", 32'(rep1[2]), 32'd0);
        @(negedge clk);
        check("rpt_first_at_8", 32'(rep1[2]), 32'd1);
        check("rpt_disabled", 32'(rep0[2]), 32'd0);
        repeat (3) @(negedge clk);
        check("rpt_second_at_11", 32'(rep1[2]), 32'd1);
        repeat (19) @(negedge clk);
        btn[2] = 1'b0;
        repeat (12) @(negedge clk);
        check("rpt_released_level", 32'(level1[2]), 32'd0);

        // simultaneous press on several channels
        btn = '0;
        repeat (12) @(negedge clk);
        btn = 5'b10101;
        repeat (6) @(negedge clk);
        check("multi_early", 32'(pressed0), 32'd0);
        @(negedge clk);
        check("multi_pressed", 32'(pressed0), 32'(5'b10101));
        check("multi_pressed_rep", 32'(pressed1), 32'(5'b10101));

        // asynchronous reset in the middle of a hold
        repeat (5) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_norep", 32'({level0, pressed0, released0, rep0}), 32'd0);
        check("async_rst_rep", 32'({level1, pressed1, released1, rep1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_no_release", 32'(released0), 32'd0);
        check("post_rst_early", 32'(pressed0), 32'd0);
        @(negedge clk);
        check("post_rst_press", 32'(pressed0), 32'(5'b10101));

        // random bouncing, channel i flips with probability 1/(6+5i) per cycle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 5 + 5 * i) == 0) btn[i] = ~btn[i];
            end
        end
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
